// File: rtl/fifo8_ctrl.sv
// Push/pop sequencing controller for the 8-entry FIFO8x9 datapath.
// Optional sticky overflow/underflow flags are built when FIFO8_CTRL_ERR_EN is defined.
module fifo8_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  output logic             push_rdy,
  output logic             pop_rdy,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             wren,
  output logic             WrInc,
  output logic             WrPtrClr,
  output logic             rden,
  output logic             RdInc,
  output logic             RdPtrClr,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [2:0]       wr_idx_q;
  logic [2:0]       rd_idx_q;
  logic             rd_valid_q;

  logic run;
  logic act;
  logic init_clr;
  logic push_acc;
  logic pop_acc;
  logic wr_wrap;
  logic rd_wrap;

  always_comb begin
    run      = (state_q == StRun);
    act      = run & ~flush;
    // INIT clears the datapath pointers only once reset has been released
    init_clr = (state_q == StInit) & rst_n;
    full     = (count_q == FullCnt);
    empty    = (count_q == '0);
    pop_acc  = act & pop & ~empty;
    push_acc = act & push & (~full | pop_acc);
    push_rdy = act & (~full | pop_acc);
    pop_rdy  = act & ~empty;
    wr_wrap  = (wr_idx_q == 3'd7);
    rd_wrap  = (rd_idx_q == 3'd7);
    wren     = push_acc;
    WrInc    = push_acc & ~wr_wrap;
    WrPtrClr = init_clr | (run & flush) | (push_acc & wr_wrap);
    rden     = pop_acc;
    RdInc    = pop_acc & ~rd_wrap;
    RdPtrClr = init_clr | (run & flush) | (pop_acc & rd_wrap);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      count_q    <= '0;
      wr_idx_q   <= 3'd0;
      rd_idx_q   <= 3'd0;
      rd_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          state_q <= StRun;
        end
        StRun: begin
          if (flush) begin
            count_q    <= '0;
            wr_idx_q   <= 3'd0;
            rd_idx_q   <= 3'd0;
            rd_valid_q <= 1'b0;
          end else begin
            rd_valid_q <= pop_acc;
            if (push_acc) wr_idx_q <= wr_wrap ? 3'd0 : wr_idx_q + 3'd1;
            if (pop_acc)  rd_idx_q <= rd_wrap ? 3'd0 : rd_idx_q + 3'd1;
            case ({push_acc, pop_acc})
              2'b10:   count_q <= count_q + 1'b1;
              2'b01:   count_q <= count_q - 1'b1;
              default: count_q <= count_q;
            endcase
          end
        end
      endcase
    end
  end

  assign count    = count_q;
  assign rd_valid = rd_valid_q;

`ifdef FIFO8_CTRL_ERR_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (run) begin
      if (flush) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if (push & ~push_acc) overflow_q  <= 1'b1;
        if (pop & ~pop_acc)   underflow_q <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo8_ctrl.sv
// Bench for fifo8_ctrl: vector table plus corner sequences, with a behavioural FIFO8x9
// datapath driven by the DUT strobes and a scoreboard queue checking popped data.
module tb_fifo8_ctrl;

  logic       clk;
  logic       rst_n;
  logic       push;
  logic       pop;
  logic       flush;
  logic       push_rdy;
  logic       pop_rdy;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       wren;
  logic       WrInc;
  logic       WrPtrClr;
  logic       rden;
  logic       RdInc;
  logic       RdPtrClr;
  logic       overflow;
  logic       underflow;

  fifo8_ctrl #(.DEPTH(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .push_rdy (push_rdy),
    .pop_rdy  (pop_rdy),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .wren     (wren),
    .WrInc    (WrInc),
    .WrPtrClr (WrPtrClr),
    .rden     (rden),
    .RdInc    (RdInc),
    .RdPtrClr (RdPtrClr),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO8x9 datapath with full 8-bit pointers
  logic [7:0] din;
  logic [7:0] mem [256];
  logic [7:0] wptr = 8'd0;
  logic [7:0] rptr = 8'd0;
  logic [7:0] dout = 8'd0;

  always @(posedge clk) begin
    if (wren) mem[wptr] <= din;
    if (WrPtrClr)   wptr <= 8'd0;
    else if (WrInc) wptr <= wptr + 8'd1;
    if (rden) dout <= mem[rptr];
    if (RdPtrClr)   rptr <= 8'd0;
    else if (RdInc) rptr <= rptr + 8'd1;
  end

  typedef struct {
    logic       push, pop, flush;
    logic [7:0] din;
    int         cnt;
    logic       prdy, wr, winc, wclr, rd, rinc, rclr;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];
  int         total = 0;
  int         bad = 0;
  int         row = 0;
  logic       exp_rdv = 1'b0;
  logic       exp_ovf = 1'b0;
  logic       exp_udf = 1'b0;

  function automatic vec_t mk(input logic pu, input logic po, input logic fl,
                              input logic [7:0] d, input int c, input logic prdy,
                              input logic wr, input logic winc, input logic wclr,
                              input logic rd, input logic rinc, input logic rclr);
    vec_t v;
    v.push = pu; v.pop = po; v.flush = fl; v.din = d; v.cnt = c; v.prdy = prdy;
    v.wr = wr; v.winc = winc; v.wclr = wclr; v.rd = rd; v.rinc = rinc; v.rclr = rclr;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL row %0d %s: got %0d (0x%0h) want %0d (0x%0h)", row, name, act, act, exp, exp);
    end
  endtask

  // Drive one RUN cycle just after a rising edge, check mid-cycle, then advance
  task automatic apply(input vec_t v);
    push = v.push; pop = v.pop; flush = v.flush; din = v.din;
    #4;
    chk("count", int'(count), v.cnt);
    chk("full", int'(full), int'(v.cnt == 8));
    chk("empty", int'(empty), int'(v.cnt == 0));
    chk("push_rdy", int'(push_rdy), int'(v.prdy));
    chk("pop_rdy", int'(pop_rdy), int'(!v.flush && v.cnt != 0));
    chk("wren", int'(wren), int'(v.wr));
    chk("WrInc", int'(WrInc), int'(v.winc));
    chk("WrPtrClr", int'(WrPtrClr), int'(v.wclr));
    chk("rden", int'(rden), int'(v.rd));
    chk("RdInc", int'(RdInc), int'(v.rinc));
    chk("RdPtrClr", int'(RdPtrClr), int'(v.rclr));
    chk("rd_valid", int'(rd_valid), int'(exp_rdv));
    chk("overflow", int'(overflow), int'(exp_ovf));
    chk("underflow", int'(underflow), int'(exp_udf));
    chk("ptr_range", int'(wptr < 8 && rptr < 8), 1);
    if (exp_rdv) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL row %0d dout: got 0x%0h want <scoreboard empty>", row, dout);
      end else begin
        chk("dout", int'(dout), int'(sb.pop_front()));
      end
    end
    if (v.wr) sb.push_back(v.din);
    exp_rdv = v.rd;
    if (v.flush) begin
      sb.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end
`ifdef FIFO8_CTRL_ERR_EN
    else begin
      if (v.push && !v.wr) exp_ovf = 1'b1;
      if (v.pop && !v.rd)  exp_udf = 1'b1;
    end
`endif
    @(posedge clk);
    #1;
    row++;
  endtask

  task automatic check_reset_state();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_WrPtrClr", int'(WrPtrClr), 0);
    chk("rst_RdPtrClr", int'(RdPtrClr), 0);
    chk("rst_push_rdy", int'(push_rdy), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_underflow", int'(underflow), 0);
  endtask

  task automatic check_init();
    #4;
    chk("init_WrPtrClr", int'(WrPtrClr), 1);
    chk("init_RdPtrClr", int'(RdPtrClr), 1);
    chk("init_push_rdy", int'(push_rdy), 0);
    chk("init_pop_rdy", int'(pop_rdy), 0);
    chk("init_wren", int'(wren), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; din = 8'd0;

    // Fill, drain, refill, push+pop while full, drain with wrap mid-way
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1, 0, 0, 8'(8'h11 * (k + 1)), k, 1, 1, k != 7, k == 7, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'hEE, 8, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 1, 0, 8'h00, 8 - k, 1, 0, 0, 0, 1, k != 7, k == 7));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1, 0, 0, 8'(8'h11 * (k + 1)), k, 1, 1, k != 7, k == 7, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 8'h99, 8, 1, 1, 1, 0, 1, 1, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 1, 0, 8'h00, 8 - k, 1, 0, 0, 0, 1, k != 6, k == 6));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0));

    @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;
    check_init();

    foreach (tbl[i]) apply(tbl[i]);

    // Empty with push+pop: only the push goes through
    apply(mk(1, 1, 0, 8'hA1, 0, 1, 1, 1, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      apply(mk(1, 0, 0, 8'(8'hA2 + k), k + 1, 1, 1, 1, 0, 0, 0, 0));
    // Flush beats a simultaneous push
    apply(mk(1, 0, 1, 8'hB0, 5, 0, 0, 0, 1, 0, 0, 1));
    apply(mk(0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 0, 0, 8'hC1, 0, 1, 1, 1, 0, 0, 0, 0));
    chk("entry0_after_flush", int'(mem[0]), 'hC1);
    apply(mk(0, 1, 0, 8'h00, 1, 1, 0, 0, 0, 1, 1, 0));
    apply(mk(0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0));

    // Reset while a popped word is about to be reported
    apply(mk(1, 0, 0, 8'hD1, 0, 1, 1, 1, 0, 0, 0, 0));
    apply(mk(0, 1, 0, 8'h00, 1, 1, 0, 0, 0, 1, 1, 0));
    push = 1'b0; pop = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    sb.delete();
    exp_rdv = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_init();
    apply(mk(1, 0, 0, 8'hE1, 0, 1, 1, 1, 0, 0, 0, 0));
    apply(mk(0, 1, 0, 8'h00, 1, 1, 0, 0, 0, 1, 1, 0));
    apply(mk(0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo8_ctrl.md
# fifo8_ctrl

Sequencing controller for the 8-entry FIFO8x9 datapath: turns a requester-side push/pop handshake into the FIFO's WrInc/WrPtrClr/wren and RdInc/RdPtrClr/rden strobes. It tracks occupancy and exposes full/empty/count. It keeps 3-bit shadow pointers so the datapath's 8-bit pointers never index past entry 7: wrap is performed by a pointer clear instead of an increment. It sits between the requesting logic and FIFO8x9, one instance per FIFO.

## Interface
- DEPTH, 8, number of FIFO entries; fixed at 8 (shadow pointers are 3 bits).
- CNT_W, 4, width of `count` (holds 0..DEPTH).
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- push  in  1  requester wants to write DataIn this cycle.
- pop  in  1  requester wants to read one entry this cycle.
- flush  in  1  discard all contents.
- push_rdy  out  1  push will be accepted this cycle (combinational).
- pop_rdy  out  1  pop will be accepted this cycle (combinational).
- rd_valid  out  1  FIFO DataOut holds the popped word (registered).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  CNT_W  current occupancy.
- wren, WrInc, WrPtrClr  out  1 each  write-side strobes to FIFO8x9.
- rden, RdInc, RdPtrClr  out  1 each  read-side strobes to FIFO8x9.
- overflow, underflow  out  1 each  sticky error flags (see Configuration).

## Operation
- FSM states: INIT, RUN.
  - Reset enters INIT.
  - INIT lasts exactly one cycle: WrPtrClr = RdPtrClr = 1; push_rdy = pop_rdy = 0. It then goes to RUN.
  - RUN is held until reset.
- Accept rules in RUN with flush = 0:
  - pop_acc = pop & !empty.
  - push_acc = push & (!full | pop_acc).
- Push accepted:
  - wren = 1, in the same cycle.
  - If wr_idx != 7: WrInc = 1, and wr_idx increments.
  - If wr_idx == 7: WrPtrClr = 1 and WrInc = 0, and wr_idx goes to 0.
- Pop accepted: same rule on the read side, using rden, RdInc/RdPtrClr and rd_idx.
- count next value:
  - Push only: +1.
  - Pop only: −1.
  - Both or neither: unchanged.
- flush = 1 in RUN:
  - Asserts WrPtrClr = RdPtrClr = 1.
  - Forces wren = rden = WrInc = RdInc = 0 and push_rdy = pop_rdy = 0.
  - Next state: count = 0, wr_idx = rd_idx = 0, rd_valid = 0.
  - Flush has priority over push/pop in the same cycle.
- Empty + push + pop: only the push is accepted. There is no fall-through; count goes 0→1.
- Full + push + pop: both are accepted; count stays 8.
- Strobes are combinational from state, indices and inputs. All of them are 0 whenever the corresponding accept is 0.

## Timing
- Reset values:
  - state = INIT, count = 0, wr_idx = rd_idx = 0.
  - rd_valid = 0, overflow = underflow = 0.
  - full = 0, empty = 1.
- Strobes during reset: all 0, except WrPtrClr = RdPtrClr = 0 while rst_n is low (INIT drives them only after release).
- Write latency: the entry is stored at the clk edge ending the accept cycle.
- Read latency: DataOut is valid and rd_valid = 1 in the cycle after pop_acc. rd_valid is a single-cycle pulse per pop.
- full, empty and count are registered. They reflect accepts one cycle later; push_rdy/pop_rdy use these registered values.
- rst_n asserted mid-operation: all state clears immediately. In-flight rd_valid is dropped. The FSM re-runs INIT after release.

## Configuration
- FIFO8_CTRL_ERR_EN defined:
  - overflow sets when push = 1 and push_acc = 0 while in RUN and not flushing.
  - underflow sets when pop = 1 and pop_acc = 0 under the same conditions.
  - Both are sticky until flush or reset.
- FIFO8_CTRL_ERR_EN undefined: overflow and underflow are tied to 0, and no error logic is built.

## Test plan
- Reset release → one cycle with WrPtrClr = RdPtrClr = 1 and push_rdy = 0; then push_rdy = 1, empty = 1, count = 0.
- 8 pushes (0x11..0x88) → count = 8, full = 1, push_rdy = 0. The 8th push shows WrPtrClr = 1, WrInc = 0.
- 8 pops after the fill → DataOut 0x11..0x88, each with rd_valid one cycle after pop. The 8th pop uses RdPtrClr; empty = 1 at the end.
- Full, then simultaneous push 0x99 + pop → count stays 8. A subsequent drain yields 0x22..0x88 then 0x99.
- Empty, then simultaneous push + pop → only wren asserts, rden = 0, count = 1. With FIFO8_CTRL_ERR_EN, underflow = 1.
- Count = 5, then flush together with push → no wren; next cycle count = 0, empty = 1, overflow/underflow cleared. A new push writes to entry 0.
